// File: rtl/decrypt_payload_tagger_if.sv
// Upstream/downstream packet-stream handshake bundle for decrypt_payload_tagger.
// The tagger itself takes the slave view; the stream source/sink takes the master view.
interface decrypt_payload_tagger_if;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        out_inside_payload;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr, out_inside_payload
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr, out_inside_payload
  );
endinterface

// File: rtl/decrypt_payload_tagger.sv
// Tags payload words ahead of the decryption pipeline, buffers them in a 2-entry
// skid FIFO and holds the decryption key stable while packets are in flight.
//
// state  | meaning
// S_IDLE | between packets; module headers and stray words pass with tag 0
// S_DATA | inside a packet; words beyond the protocol header get tagged
module decrypt_payload_tagger #(
  parameter int HDR_WORDS    = 6,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  decrypt_payload_tagger_if.slave bus,
  input  logic        cfg_en,
  input  logic [79:0] cfg_key,
  input  logic        cfg_key_load,
  output logic        key_busy,
  output logic [79:0] key
);

  localparam int CW = $clog2(HDR_WORDS + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic            pkt_en_q, pkt_en_d;
  logic            tag_in;
  logic            acc;

  logic [72:0]     mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic [72:0]     head;
  logic [72:0]     last_q;
  logic [72:0]     shown;
  logic            pop;

  logic [79:0]     key_pend;
  logic [DW-1:0]   drain;
  logic            commit;

  assign acc = bus.in_wr && bus.in_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      pkt_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      pkt_en_q   <= pkt_en_d;
    end
  end

  // Data word 0 is consumed in S_IDLE, so the count starts at 1 on entry.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pkt_en_d   = pkt_en_q;
    tag_in     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc && bus.in_ctrl == 8'h00) begin
          state_d    = S_DATA;
          word_cnt_d = CW'(1);
          pkt_en_d   = cfg_en;
        end
      end
      S_DATA: begin
        tag_in = pkt_en_q && (word_cnt_q >= CW'(HDR_WORDS));
        if (acc) begin
          if (bus.in_ctrl == 8'h00) begin
            if (word_cnt_q < CW'(HDR_WORDS))
              word_cnt_d = word_cnt_q + CW'(1);
          end else begin
            state_d    = S_IDLE;
            word_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_rdy = (count != 2'd2);
  assign bus.out_wr = (count != 2'd0) && bus.out_rdy;
  assign pop        = bus.out_wr;
  assign head       = mem[rd_ptr];
  // Outputs keep showing the last popped word once the FIFO runs empty.
  assign shown      = (count != 2'd0) ? head : last_q;
  assign bus.out_inside_payload = shown[72];
  assign bus.out_ctrl           = shown[71:64];
  assign bus.out_data           = shown[63:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      last_q <= '0;
    end else begin
      if (acc) begin
        mem[wr_ptr] <= {tag_in, bus.in_ctrl, bus.in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        last_q <= head;
      end
      case ({acc, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign commit = key_busy && (state_q == S_IDLE) && (count == 2'd0) &&
                  (drain == '0) && !acc;

  // A load landing in the commit cycle keeps busy set so the newer key follows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key      <= '0;
      key_pend <= '0;
      key_busy <= 1'b0;
      drain    <= '0;
    end else begin
      if (pop)
        drain <= DW'(DRAIN_CYCLES);
      else if (drain != '0)
        drain <= drain - DW'(1);
      if (cfg_key_load)
        key_pend <= cfg_key;
      if (commit)
        key <= key_pend;
      if (cfg_key_load)
        key_busy <= 1'b1;
      else if (commit)
        key_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decrypt_payload_tagger.sv
// Scoreboard bench for decrypt_payload_tagger: stimulus pushes hand-computed
// {tag,ctrl,data} entries, a negedge monitor pops and compares on every out_wr.
module tb_decrypt_payload_tagger;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_en;
  logic [79:0] cfg_key;
  logic        cfg_key_load;
  logic        key_busy;
  logic [79:0] key;

  decrypt_payload_tagger_if bus();

  decrypt_payload_tagger #(.HDR_WORDS(6), .DRAIN_CYCLES(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .cfg_en       (cfg_en),
    .cfg_key      (cfg_key),
    .cfg_key_load (cfg_key_load),
    .key_busy     (key_busy),
    .key          (key)
  );

  always #5 clk = ~clk;

  localparam logic [79:0] K1 = 80'h0123_4567_89AB_CDEF_89AB;
  localparam logic [79:0] K2 = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [79:0] K3 = 80'h1357_9BDF_2468_ACE0_FFFF;
  localparam logic [79:0] K4 = 80'hDEAD_BEEF_CAFE_F00D_1234;
  // Per-word tags of a 12-word stream (2 module headers + 10 data words), bit i = word i.
  localparam logic [11:0] TAGS_ON  = 12'hF00;
  localparam logic [11:0] TAGS_OFF = 12'h000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_out_cyc = 0;
  bit lat_chk = 1'b0;
  logic [72:0] exp_q[$];
  int          cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_wr === 1'b1) begin
      last_out_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %h expected nothing",
                 {bus.out_inside_payload, bus.out_ctrl, bus.out_data});
      end else begin
        logic [72:0] e;
        int pc;
        e  = exp_q.pop_front();
        pc = cyc_q.pop_front();
        if ({bus.out_inside_payload, bus.out_ctrl, bus.out_data} !== e) begin
          bad++;
          $display("FAIL out_word: got %h expected %h",
                   {bus.out_inside_payload, bus.out_ctrl, bus.out_data}, e);
        end
        if (lat_chk) begin
          total++;
          if (cyc - pc != 1) begin
            bad++;
            $display("FAIL latency: got %0d expected 1", cyc - pc);
          end
        end
      end
    end
  end

  // Holds the word until in_rdy, then records the expected output entry.
  task automatic send(input logic [63:0] d, input logic [7:0] c, input logic t);
    int n = 0;
    bus.in_data = d;
    bus.in_ctrl = c;
    bus.in_wr   = 1'b1;
    while (!bus.in_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_rdy) begin
      check("in_rdy_timeout", 80'(bus.in_rdy), 80'd1);
    end else begin
      exp_q.push_back({t, c, d});
      cyc_q.push_back(cyc);
      @(posedge clk); #1;
    end
    bus.in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic en0, input logic en1, input logic [11:0] tags,
                          input logic [63:0] base);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] c;
      c = (i < 2) ? 8'hFF : ((i == 11) ? 8'h04 : 8'h00);
      cfg_en = (i <= 2) ? en0 : en1;
      send(base + 64'(i), c, tags[i]);
    end
  endtask

  task automatic load_key(input logic [79:0] k);
    cfg_key      = k;
    cfg_key_load = 1'b1;
    @(posedge clk); #1;
    cfg_key_load = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    int changes;
    int first_ch;
    int n;
    logic [79:0] prev;

    reset_n      = 1'b0;
    cfg_en       = 1'b0;
    cfg_key      = '0;
    cfg_key_load = 1'b0;
    bus.in_data  = '0;
    bus.in_ctrl  = '0;
    bus.in_wr    = 1'b0;
    bus.out_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // T1: reset values, then a single key commit while idle
    check("rst_in_rdy",   80'(bus.in_rdy), 80'd1);
    check("rst_out_wr",   80'(bus.out_wr), 80'd0);
    check("rst_out_data", 80'(bus.out_data), 80'd0);
    check("rst_out_ctrl", 80'(bus.out_ctrl), 80'd0);
    check("rst_tag",      80'(bus.out_inside_payload), 80'd0);
    check("rst_key",      key, 80'd0);
    check("rst_key_busy", 80'(key_busy), 80'd0);
    load_key(K1);
    check("t1_busy_set",  80'(key_busy), 80'd1);
    check("t1_key_held",  key, 80'd0);
    prev = key; changes = 0; first_ch = -1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (key !== prev) begin
        changes++;
        if (first_ch < 0) first_ch = i;
      end
      prev = key;
    end
    check("t1_key_changes", 80'(changes), 80'd1);
    check("t1_commit_cycle", 80'(first_ch), 80'd0);
    check("t1_key_value", key, K1);
    check("t1_busy_clear", 80'(key_busy), 80'd0);

    // T2: tagged packet with continuous downstream ready and 1-cycle latency
    lat_chk = 1'b1;
    send_pkt(1'b1, 1'b1, TAGS_ON, 64'h1000_0000_0000_0000);
    wait_empty("t2_drain");
    lat_chk = 1'b0;

    // T3: disabled packet, then cfg_en toggled mid-packet both ways
    send_pkt(1'b0, 1'b0, TAGS_OFF, 64'h2000_0000_0000_0000);
    send_pkt(1'b1, 1'b0, TAGS_ON,  64'h3000_0000_0000_0000);
    send_pkt(1'b0, 1'b1, TAGS_OFF, 64'h4000_0000_0000_0000);
    wait_empty("t3_drain");

    // T4: downstream stalled for 5 cycles under a burst
    bus.out_rdy = 1'b0;
    fork
      send_pkt(1'b1, 1'b1, TAGS_ON, 64'h5000_0000_0000_0000);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("t4_in_rdy_full", 80'(bus.in_rdy), 80'd0);
        check("t4_out_wr_stall", 80'(bus.out_wr), 80'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_still_full", 80'(bus.in_rdy), 80'd0);
        bus.out_rdy = 1'b1;
      end
    join
    wait_empty("t4_drain");
    repeat (10) @(posedge clk);
    #1;

    // T5: two loads mid-packet; only the later one commits, after drain
    fork
      send_pkt(1'b1, 1'b1, TAGS_ON, 64'h6000_0000_0000_0000);
      begin
        repeat (4) @(posedge clk);
        #1;
        load_key(K2);
        repeat (2) @(posedge clk);
        #1;
        load_key(K3);
      end
    join
    check("t5_key_held", key, K1);
    n = 0;
    while (key === K1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_key_value", key, K3);
    check("t5_commit_delay", 80'(cyc - last_out_cyc), 80'd8);
    check("t5_busy_clear", 80'(key_busy), 80'd0);
    wait_empty("t5_drain");

    // T6: reset with 2 words buffered and a key pending
    bus.out_rdy = 1'b0;
    send(64'h7000_0000_0000_0001, 8'h00, 1'b0);
    send(64'h7000_0000_0000_0002, 8'h00, 1'b0);
    load_key(K4);
    check("t6_full", 80'(bus.in_rdy), 80'd0);
    check("t6_busy", 80'(key_busy), 80'd1);
    reset_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_rdy = 1'b1;
    check("t6_in_rdy", 80'(bus.in_rdy), 80'd1);
    check("t6_out_wr", 80'(bus.out_wr), 80'd0);
    check("t6_key_busy", 80'(key_busy), 80'd0);
    check("t6_key", key, 80'd0);
    send_pkt(1'b1, 1'b1, TAGS_ON, 64'h8000_0000_0000_0000);
    wait_empty("t6_drain");
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_late_commit", key, 80'd0);
    check("t6_busy_idle", 80'(key_busy), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
